// File: rtl/shield_tag_coalescer.sv
// Packs per-data-line HMAC tags into masked tag-memory line writes.
// One line is buffered; it drains when full, on an address/slot conflict, or on flush.

module shield_tag_slot #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      full <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end
  end
endmodule

module shield_tag_coalescer #(
  parameter int SHIELD_ADDR_WIDTH = 32,
  parameter int LINE_WIDTH        = 512,
  parameter int HMAC_TAG_WIDTH    = 128,
  localparam int LINE_BYTES       = LINE_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SHIELD_ADDR_WIDTH-1:0] tag_base_addr,
  input  logic [HMAC_TAG_WIDTH-1:0]    tag_in,
  input  logic [SHIELD_ADDR_WIDTH-1:0] tag_in_addr,
  input  logic                         tag_in_val,
  output logic                         tag_in_rdy,
  input  logic                         flush,
  output logic [SHIELD_ADDR_WIDTH-1:0] tag_wr_addr,
  output logic [LINE_WIDTH-1:0]        tag_wr_data,
  output logic [LINE_BYTES-1:0]        tag_wr_strb,
  output logic                         tag_wr_val,
  input  logic                         tag_wr_rdy,
  output logic                         idle
);
  localparam int AW      = SHIELD_ADDR_WIDTH;
  localparam int TPL     = LINE_WIDTH / HMAC_TAG_WIDTH;
  localparam int TB      = HMAC_TAG_WIDTH / 8;
  localparam int LB_LOG  = $clog2(LINE_BYTES);
  localparam int TPL_LOG = $clog2(TPL);
  localparam int SLOT_W  = (TPL_LOG > 0) ? TPL_LOG : 1;
  localparam int TL_W    = AW - LB_LOG - TPL_LOG;

  typedef enum logic [1:0] {EMPTY, FILL, DRAIN} state_t;

  state_t                                 state;
  logic [TL_W-1:0]                        cur_tline;
  logic [AW-1:0]                          wr_addr;
  logic                                   wr_val;
  logic [TPL-1:0]                         mask;
  logic [TPL-1:0]                         sel;
  logic [TPL-1:0][HMAC_TAG_WIDTH-1:0]     slot_q;
  logic [SLOT_W-1:0]                      in_slot;
  logic [TL_W-1:0]                        in_tline;
  logic [AW-1:0]                          line_off;
  logic                                   conflict;
  logic                                   accept;
  logic                                   full_next;
  logic                                   drain_done;
  logic                                   unused_addr_bits;

  // Low address bits select a byte within the data line and carry no tag meaning.
  assign unused_addr_bits = ^tag_in_addr[LB_LOG-1:0];

  assign in_slot  = (TPL == 1) ? '0 : tag_in_addr[LB_LOG +: SLOT_W];
  assign in_tline = tag_in_addr[AW-1:LB_LOG+TPL_LOG];
  assign line_off = AW'({in_tline, {LB_LOG{1'b0}}});

  always_comb begin
    sel          = '0;
    sel[in_slot] = 1'b1;
  end

  // A tag can only merge into the open line if it targets the same tag line and a free slot.
  assign conflict   = tag_in_val && (state == FILL) &&
                      ((in_tline != cur_tline) || (|(mask & sel)));
  assign accept     = tag_in_val && tag_in_rdy;
  assign full_next  = &(mask | sel);
  assign drain_done = (state == DRAIN) && tag_wr_rdy;

  always_comb begin
    case (state)
      EMPTY:   tag_in_rdy = 1'b1;
      FILL:    tag_in_rdy = !conflict;
      default: tag_in_rdy = 1'b0;
    endcase
  end

  for (genvar s = 0; s < TPL; s++) begin : g_slot
    shield_tag_slot #(.W(HMAC_TAG_WIDTH)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (accept && sel[s]),
      .clr  (drain_done),
      .d    (tag_in),
      .q    (slot_q[s]),
      .full (mask[s])
    );
    assign tag_wr_strb[s*TB +: TB] = {TB{mask[s]}};
  end

  assign tag_wr_data = slot_q;
  assign tag_wr_addr = wr_addr;
  assign tag_wr_val  = wr_val;
  assign idle        = (state == EMPTY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      cur_tline <= '0;
      wr_addr   <= '0;
      wr_val    <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            cur_tline <= in_tline;
            wr_addr   <= tag_base_addr + line_off;
            // full_next from an empty mask is only true for one tag per line
            if (flush || full_next) begin
              state  <= DRAIN;
              wr_val <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          if ((accept && full_next) || flush || conflict) begin
            state  <= DRAIN;
            wr_val <= 1'b1;
          end
        end
        DRAIN: begin
          if (tag_wr_rdy) begin
            state  <= EMPTY;
            wr_val <= 1'b0;
          end
        end
        default: begin
          state  <= EMPTY;
          wr_val <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shield_tag_coalescer.sv
// Directed and random checks of shield_tag_coalescer against a line-level model:
// an open line (tline, slot mask, tags) and at most one closed line awaiting write.

module tb_shield_tag_coalescer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  tag_base_addr = 32'h8000_0000;
  logic [127:0] tag_in = '0;
  logic [31:0]  tag_in_addr = '0;
  logic         tag_in_val = 1'b0;
  logic         tag_in_rdy;
  logic         flush = 1'b0;
  logic [31:0]  tag_wr_addr;
  logic [511:0] tag_wr_data;
  logic [63:0]  tag_wr_strb;
  logic         tag_wr_val;
  logic         tag_wr_rdy = 1'b0;
  logic         idle;

  shield_tag_coalescer dut (
    .clk(clk), .rst(rst), .tag_base_addr(tag_base_addr),
    .tag_in(tag_in), .tag_in_addr(tag_in_addr), .tag_in_val(tag_in_val),
    .tag_in_rdy(tag_in_rdy), .flush(flush), .tag_wr_addr(tag_wr_addr),
    .tag_wr_data(tag_wr_data), .tag_wr_strb(tag_wr_strb), .tag_wr_val(tag_wr_val),
    .tag_wr_rdy(tag_wr_rdy), .idle(idle)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  // model state
  logic         m_open = 1'b0;
  int unsigned  m_tline = 0;
  logic [3:0]   m_mask = '0;
  logic [127:0] m_tag [4];
  logic         m_cl = 1'b0;
  logic [31:0]  c_addr = '0;
  logic [511:0] c_data = '0;
  logic [63:0]  c_strb = '0;

  task automatic chk(input string nm, input logic [511:0] obs, input logic [511:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic model_close();
    c_addr = tag_base_addr + m_tline * 64;
    c_data = '0;
    c_strb = '0;
    for (int s = 0; s < 4; s++)
      if (m_mask[s]) begin
        c_data[s*128 +: 128] = m_tag[s];
        c_strb[s*16 +: 16]   = 16'hFFFF;
      end
    m_cl   = 1'b1;
    m_open = 1'b0;
    m_mask = '0;
  endtask

  task automatic model_reset();
    m_open = 1'b0;
    m_cl   = 1'b0;
    m_mask = '0;
  endtask

  // One clock: drive inputs, check outputs before the edge, advance the model.
  task automatic step(input logic v, input logic [31:0] a, input logic [127:0] t,
                      input logic f, input logic wr, output logic acc);
    int unsigned tl, sl;
    logic exp_rdy;
    @(negedge clk);
    tag_in_val = v; tag_in_addr = a; tag_in = t; flush = f; tag_wr_rdy = wr;
    #1;
    tl = a / 256;
    sl = (a / 64) % 4;
    exp_rdy = !m_cl && (!v || !m_open || (tl == m_tline && !m_mask[sl]));
    chk("tag_in_rdy", 512'(tag_in_rdy), 512'(exp_rdy));
    chk("tag_wr_val", 512'(tag_wr_val), 512'(m_cl));
    chk("idle", 512'(idle), 512'(!m_open && !m_cl));
    if (m_cl) begin
      chk("tag_wr_addr", 512'(tag_wr_addr), 512'(c_addr));
      chk("tag_wr_data", tag_wr_data, c_data);
      chk("tag_wr_strb", 512'(tag_wr_strb), 512'(c_strb));
    end
    acc = v & tag_in_rdy;
    if (m_cl && wr) m_cl = 1'b0;
    if (acc) begin
      if (!m_open) begin
        m_open  = 1'b1;
        m_tline = tl;
        m_mask  = '0;
      end
      m_tag[sl]  = t;
      m_mask[sl] = 1'b1;
      if (&m_mask || f) model_close();
    end else if (m_open && (v || f)) begin
      model_close();
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [127:0] t, input logic f, input logic wr);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      step(1'b1, a, t, f, wr, acc);
      n++;
    end
    if (!acc) begin
      nchk++;
      nfail++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted addr=%0h", a);
    end
  endtask

  task automatic idle_cycles(input int n, input logic wr);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 128'h0, 1'b0, wr, acc);
  endtask

  function automatic logic [127:0] rtag();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] t0, t1, t2, t3;
  logic [31:0]  pa, prev_a;
  logic [127:0] pt;
  logic         pend, acc, f, wr;
  int           done, cyc;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_val", 512'(tag_wr_val), 512'(1'b0));
    chk("rst_wr_data", tag_wr_data, 512'(0));
    chk("rst_wr_strb", 512'(tag_wr_strb), 512'(0));
    chk("rst_wr_addr", 512'(tag_wr_addr), 512'(0));
    chk("rst_in_rdy", 512'(tag_in_rdy), 512'(1'b1));
    chk("rst_idle", 512'(idle), 512'(1'b1));
    @(negedge clk);
    rst = 1'b0;

    // sequential fill
    t0 = rtag(); t1 = rtag(); t2 = rtag(); t3 = rtag();
    send(32'h0000_0000, t0, 1'b0, 1'b1);
    send(32'h0000_0040, t1, 1'b0, 1'b1);
    send(32'h0000_0080, t2, 1'b0, 1'b1);
    send(32'h0000_00C0, t3, 1'b0, 1'b1);
    idle_cycles(1, 1'b1);
    chk("seq_addr", 512'(tag_wr_addr), 512'(32'h8000_0000));
    chk("seq_strb", 512'(tag_wr_strb), 512'({64{1'b1}}));
    chk("seq_data", tag_wr_data, {t3, t2, t1, t0});
    idle_cycles(1, 1'b1);

    // partial line plus flush
    t0 = rtag();
    send(32'h0000_1040, t0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 128'h0, 1'b1, 1'b0, acc);
    idle_cycles(1, 1'b0);
    chk("flush_addr", 512'(tag_wr_addr), 512'(32'h8000_0400));
    chk("flush_strb", 512'(tag_wr_strb), 512'(64'h0000_0000_0000_0000_0000_0000_FFFF_0000));
    chk("flush_data", tag_wr_data, {256'h0, t0, 128'h0});
    idle_cycles(2, 1'b1);

    // tline conflict: second tag waits, then opens tline 1
    t0 = rtag(); t1 = rtag();
    send(32'h0000_0000, t0, 1'b0, 1'b1);
    send(32'h0000_0100, t1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 128'h0, 1'b1, 1'b0, acc);
    idle_cycles(1, 1'b0);
    chk("conf_addr", 512'(tag_wr_addr), 512'(32'h8000_0040));
    idle_cycles(2, 1'b1);

    // duplicate slot, with 10 cycles of write backpressure
    t0 = rtag(); t1 = rtag();
    send(32'h0000_0040, t0, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0040, t1, 1'b0, 1'b0, acc);
    repeat (10) step(1'b1, 32'h0000_0040, t1, 1'b0, 1'b0, acc);
    chk("dup_data", tag_wr_data, {256'h0, t0, 128'h0});
    send(32'h0000_0040, t1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 128'h0, 1'b1, 1'b1, acc);
    idle_cycles(3, 1'b1);

    // reset while draining
    t0 = rtag();
    send(32'h0000_0080, t0, 1'b1, 1'b0);
    idle_cycles(2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstd_wr_val", 512'(tag_wr_val), 512'(1'b0));
    chk("rstd_idle", 512'(idle), 512'(1'b1));
    chk("rstd_strb", 512'(tag_wr_strb), 512'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstd_in_rdy", 512'(tag_in_rdy), 512'(1'b1));

    // random traffic near the top of the address space so line addresses wrap
    tag_base_addr = 32'hFFFF_F000;
    pend = 1'b0; done = 0; cyc = 0; prev_a = 32'h0; pa = 32'h0; pt = '0;
    while (done < 1000 && cyc < 20000) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        if ($urandom_range(0, 1) == 1) pa = prev_a + 32'd64;
        else begin
          pa = ($urandom_range(0, 15) << 6) | $urandom_range(0, 63);
          if ($urandom_range(0, 9) == 0) pa = pa | 32'hFFFF_0000;
        end
        prev_a = pa;
        pt = rtag();
      end
      f  = ($urandom_range(0, 7) == 0);
      wr = ($urandom_range(0, 1) == 1);
      step(pend, pa, pt, f, wr, acc);
      if (acc) begin
        pend = 1'b0;
        done++;
      end
      cyc++;
    end
    if (done < 1000) begin
      nchk++;
      nfail++;
      $error("FAIL random_budget observed=%0d expected=1000", done);
    end
    step(1'b0, 32'h0, 128'h0, 1'b1, 1'b1, acc);
    idle_cycles(4, 1'b1);
    chk("final_idle", 512'(idle), 512'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule
